// File: rtl/filter_pkg.sv
// Shared definitions for the masked 2D filter datapath: default geometry
// and the two-state FSM encoding used by the kernel-side controllers.
package filter_pkg;
  localparam int PIXEL_BITS = 8;
  localparam int KERNEL_N   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..MAX with clear and increment; wrap flags the terminal
// count so callers can detect the end of a sequence without a comparator.
module mod_counter #(
  parameter  int MAX = 2,
  localparam int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = (count == W'(MAX));

  // clr wins over inc so a reload on the terminal beat restarts at 0
  always_ff @(posedge clk) begin
    if (!rst)     count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= wrap ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/window_serializer.sv
// Parallel-in/serial-out window serializer: emits slice 0 first on a
// valid/ready stream; the next window may load on the last beat.
module window_serializer
  import filter_pkg::*;
#(
  parameter int bits = PIXEL_BITS,
  parameter int N    = KERNEL_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [bits*N-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [bits-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);
  localparam int CW = (N < 2) ? 1 : $clog2(N);

  state_t state, state_nxt;
  logic [N-1:0][bits-1:0] sreg;
  logic [CW-1:0] beat_idx_unused;
  logic last, beat, load;

  mod_counter #(.MAX(N - 1)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (beat && !last),
    .clr   (load),
    .count (beat_idx_unused),
    .wrap  (last)
  );

  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign out_data  = sreg[0];
  assign out_last  = (state == SHIFT) && last;
  assign beat      = out_valid && out_ready;
  // Only combinational in->out path: lets the next window load on the last beat
  assign in_ready  = (state == IDLE) || ((state == SHIFT) && out_ready && last);
  assign load      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (beat && last) state_nxt = in_valid ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= in_data;
    end else if (beat && !last) begin
      for (int i = 0; i < N - 1; i++) sreg[i] <= sreg[i+1];
      sreg[N-1] <= '0;
    end
  end
endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer (bits=8, N=3): basic drain, round
// trip, backpressure, back-to-back, ignored load and mid-window reset.
module tb_window_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  window_serializer #(.bits(8), .N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input string tag, input logic [7:0] d, input logic l);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [23:0] ksr;

    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);

    // basic
    in_data = 24'h030201; in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    px("basic0", 8'h01, 1'b0);
    chk("basic0_inrdy", 32'(in_ready), 32'd0);
    tick(); px("basic1", 8'h02, 1'b0);
    tick(); px("basic2", 8'h03, 1'b1);
    chk("basic2_inrdy", 32'(in_ready), 32'd1);
    tick(); idle_chk("basic_idle");

    // round trip through a serial-in shift register (new sample enters on top)
    ksr = '0;
    ksr = {8'hAA, ksr[23:8]};
    ksr = {8'hBB, ksr[23:8]};
    ksr = {8'hCC, ksr[23:8]};
    in_data = ksr; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    px("rt0", 8'hAA, 1'b0);
    tick(); px("rt1", 8'hBB, 1'b0);
    tick(); px("rt2", 8'hCC, 1'b1);
    tick(); idle_chk("rt_idle");

    // backpressure: out_ready 1,0,0,1,0,1
    in_data = 24'h030201; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    out_ready = 1'b1; px("bp0", 8'h01, 1'b0);
    tick(); out_ready = 1'b0; px("bp1", 8'h02, 1'b0);
    tick(); out_ready = 1'b0; px("bp2", 8'h02, 1'b0);
    tick(); out_ready = 1'b1; px("bp3", 8'h02, 1'b0);
    tick(); out_ready = 1'b0; px("bp4", 8'h03, 1'b1);
    chk("bp4_inrdy", 32'(in_ready), 32'd0);
    tick(); out_ready = 1'b1; px("bp5", 8'h03, 1'b1);
    chk("bp5_inrdy", 32'(in_ready), 32'd1);
    tick(); idle_chk("bp_idle");

    // back-to-back
    in_data = 24'h030201; in_valid = 1'b1;
    tick(); in_data = 24'h060504;
    px("b2b0", 8'h01, 1'b0); chk("b2b0_inrdy", 32'(in_ready), 32'd0);
    tick(); px("b2b1", 8'h02, 1'b0); chk("b2b1_inrdy", 32'(in_ready), 32'd0);
    tick(); px("b2b2", 8'h03, 1'b1); chk("b2b2_inrdy", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    px("b2b3", 8'h04, 1'b0); chk("b2b3_inrdy", 32'(in_ready), 32'd0);
    tick(); px("b2b4", 8'h05, 1'b0);
    tick(); px("b2b5", 8'h06, 1'b1);
    tick(); idle_chk("b2b_idle");

    // ignored load while 0x02 pending
    in_data = 24'h030201; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    px("ign0", 8'h01, 1'b0);
    tick(); in_data = 24'hFFFFFF; in_valid = 1'b1;
    px("ign1", 8'h02, 1'b0); chk("ign1_inrdy", 32'(in_ready), 32'd0);
    tick(); in_valid = 1'b0;
    px("ign2", 8'h03, 1'b1);
    tick(); idle_chk("ign_idle");

    // reset mid-window after 0x01 accepted
    in_data = 24'h030201; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    px("mr0", 8'h01, 1'b0);
    tick(); rst = 1'b0;
    px("mr1", 8'h02, 1'b0);
    tick(); rst = 1'b1;
    idle_chk("mr_rst");
    chk("mr_rst_data", 32'(out_data), 32'd0);
    chk("mr_rst_last", 32'(out_last), 32'd0);
    tick(); idle_chk("mr_rel0");
    tick(); idle_chk("mr_rel1");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/window_serializer.md
# window_serializer

Parallel-in/serial-out converter for the masked 2D filter datapath. It takes one N-element window of `bits`-wide pixels as a single parallel word and emits the pixels one per beat on a valid/ready stream. The lowest slice goes first, so the original sample order written by the kernel's serial-in shift register is restored. It sits between the kernel and the downstream pixel stream: write-back, debug tap, or the next filter stage.

## Interface
- `bits`, 8, pixel width.
- `N`, 3, pixels per window; must be ≥1.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_data` input bits*N: window; slice i is `in_data[bits*i +: bits]`.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts a window this cycle.
- `out_data` output bits: current pixel.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts the pixel.
- `out_last` output 1: current pixel is slice N-1 of its window.
- `busy` output 1: a window is loaded and not fully drained.

## Operation
- Load handshake: `in_valid && in_ready`. Output handshake (a "beat"): `out_valid && out_ready`.
- State machine with two states:
  - IDLE: `in_ready=1`, `out_valid=0`. On load, capture `in_data` into the shift register, set beat counter to 0, go to SHIFT.
  - SHIFT: `out_valid=1`, `out_data` = slice 0 of the shift register.
    - On a beat that is not the last: shift the register down by `bits` (slice i+1 moves to slice i, top slice zero-filled) and increment the counter.
    - On the last beat (counter = N-1): if `in_valid`, load the new window and stay in SHIFT with counter 0; else go to IDLE.
- `in_ready` = IDLE || (SHIFT && `out_ready` && counter = N-1). This is combinational from `out_ready`, and is the only combinational input-to-output path.
- `out_last` = SHIFT && counter = N-1.
- `busy` = SHIFT.
- Counter width is max(1, $clog2(N)). It never exceeds N-1 and wraps to 0 only via load.
- N=1: every beat is last; back-to-back windows stream at one pixel per cycle.
- `in_valid` while busy and not on the last beat: ignored, no capture. Upstream must hold its data per valid/ready rules.
- While `out_valid && !out_ready`, `out_data` and `out_last` are held stable, and the counter and register do not change.
- Reset values: state IDLE, shift register all zeros, counter 0. Hence `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`, `in_ready=1`.
- Reset mid-window discards the remaining pixels. No partial window is emitted after reset release.
- Reset has priority over every handshake in the same cycle.

## Timing
- Latency: a load at edge t puts slice 0 on `out_data` with `out_valid=1` in the cycle after t.
- Throughput with `out_ready` held high: one pixel per cycle, N cycles per window.
- Back-to-back windows: zero bubble. The load coincides with the last beat of the previous window.
- Pixel k of a window appears after exactly k beats following the load, independent of stall pattern.

## Structure
- Shared package `filter_pkg`: `PIXEL_BITS` (8) and `KERNEL_N` (3) defaults, plus the two-value state enum (IDLE, SHIFT) shared with other kernel FSMs.
- One natural sub-module: `mod_counter` (parameter MAX, with inc/clr and a wrap flag) for the beat counter; it is reusable by the kernel's line-position logic.
- The shift register itself stays inline: it is a parallel-load variant, and `shift_reg` cannot be reused unchanged.

## Test plan
- Basic (bits=8, N=3): load `in_data=0x030201`, `out_ready=1`. Expect `out_data` 0x01, 0x02, 0x03 on three consecutive cycles, `out_last` only with 0x03, then IDLE with `in_ready=1`.
- Round trip: feed 0xAA, 0xBB, 0xCC into the kernel shift register, then load its 0xCCBBAA output. Expect serial 0xAA, 0xBB, 0xCC.
- Backpressure: load 0x030201 and toggle `out_ready` 1,0,0,1,0,1. Expect 0x02 held through the stall cycles, the pixel sequence unchanged, and `out_last` still with 0x03.
- Back-to-back: `in_valid` held high with 0x030201 then 0x060504, `out_ready=1`. Expect 01,02,03,04,05,06 with no gap and `in_ready` high only in the cycle 0x03 is accepted.
- Ignored load: pulse `in_valid` with 0xFFFFFF while 0x02 is pending. Expect no capture and the sequence 01,02,03 intact.
- Reset mid-operation: assert `rst=0` after 0x01 is accepted. Next cycle expect `out_valid=0`, `out_data=0`, `busy=0`, `in_ready=1`, and no 0x02/0x03 after release.
